mult_arbiter: RTL



---
 rtl/mult_arbiter_pkg.sv | 16 +
 rtl/multiplier_carrysave.sv | 32 +++
 rtl/mult_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
package mult_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Round-robin successor of idx among n requesters
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/multiplier_carrysave.sv
// Unsigned N x N multiplier: carry-save accumulation of partial products, one final add.
module multiplier_carrysave #(
    parameter int unsigned N = 24
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    localparam int unsigned PW = 2 * N;

    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
    logic [PW-1:0] pp;
    logic [PW-1:0] maj;

    // 3:2 compress each partial product into the sum/carry pair, then resolve
    always_comb begin
        sum   = '0;
        carry = '0;
        pp    = '0;
        maj   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pp    = b[i] ? (PW'(a) << i) : '0;
            maj   = (sum & carry) | (sum & pp) | (carry & pp);
            sum   = sum ^ carry ^ pp;
            carry = maj << 1;
        end
        p = sum + carry;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 24,
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2*N-1:0]      res_p,
    output logic [IDW-1:0]      res_id,
    output logic                busy
);

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic            grant_found;
    logic            accept;
    int unsigned     scan_idx;
    logic [N-1:0]    a_arr [NREQ];
    logic [N-1:0]    b_arr [NREQ];
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [IDW-1:0]  op_id;
    logic [2*N-1:0]  prod;

    // Unpack the per-requester operand buses
    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign a_arr[k] = req_a[k*N +: N];
        assign b_arr[k] = req_b[k*N +: N];
    end

    // First valid requester at or above rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = (32'(rr_ptr) + i) % NREQ;
            if (!grant_found && req_valid[IDW'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan_idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant outputs; rst_n gating keeps req_ready low throughout reset
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
            accept               = 1'b1;
        end
    end

    multiplier_carrysave #(.N(N)) u_mult (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // Operand capture, pointer advance, result capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            res_p     <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= a_arr[grant_idx];
                op_b   <= b_arr[grant_idx];
                op_id  <= grant_idx;
                rr_ptr <= IDW'(rr_next(32'(grant_idx), NREQ));
            end
            if (state == CALC) begin
                res_p  <= prod;
                res_id <= op_id;
            end
            res_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

endmodule
